mips_multicycle_control: RTL
============================

# mips_multicycle_control

Moore-style main controller for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several cycles. It drives every datapath select, including the immediate sign/zero-extension select, and stalls on a memory ready handshake. It sits between the instruction register opcode field and the datapath muxes, register file, ALU control and PC logic.

## Interface
- No parameters.
- One clock; reset is synchronous and active-high.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `opcode` input 6: IR[31:26]. Stable from the cycle after IR load.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if `zero`.
- `i_or_d` output 1: 0 = PC address, 1 = ALUOut address.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `ir_write` output 1: load IR.
- `mem_to_reg` output 1: register write data, 0 = ALUOut, 1 = MDR.
- `reg_dst` output 1: destination, 0 = rt, 1 = rd.
- `reg_write` output 1: register file write enable.
- `alu_src_a` output 1: 0 = PC, 1 = A.
- `alu_src_b` output 2: 0 = B, 1 = const 4, 2 = ext imm, 3 = ext imm << 2.
- `alu_op` output 2: 0 = add, 1 = sub, 2 = funct, 3 = opcode-decoded I-type.
- `pc_source` output 2: 0 = ALU, 1 = ALUOut, 2 = jump target.
- `ext_sign` output 1: extender mode, 0 = zero-extend, 1 = sign-extend.
- `illegal` output 1: illegal opcode indication.
- `state` output 4: current state, debug.
- `instr_count` output 32: retired-fetch counter.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5
  - R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXEC = 10, I_WB = 11, TRAP = 12
- Decoded opcodes:
  - R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010
  - addi = 001000, slti = 001010, andi = 001100, ori = 001101
- Transitions:
  - FETCH → DECODE when `mem_ready`; otherwise hold.
  - DECODE dispatches on `opcode`:
    - lw/sw → MEM_ADDR
    - R → R_EXEC
    - beq → BRANCH
    - j → JUMP
    - addi/slti/andi/ori → I_EXEC
    - any other opcode → illegal path (see Configuration).
  - MEM_ADDR → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD → MEM_WB when `mem_ready`; otherwise hold.
  - MEM_WR → FETCH when `mem_ready`; otherwise hold.
  - R_EXEC → R_WB; I_EXEC → I_WB.
  - MEM_WB, R_WB, I_WB, BRANCH, JUMP → FETCH.
- Outputs are a pure decode of `state` (plus `mem_ready` gating). Signals not listed for a state are 0.
  - FETCH: `mem_read`=1, `alu_src_b`=1, `ir_write` = `pc_write` = `mem_ready`.
  - DECODE: `alu_src_b`=3 (branch target precompute).
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2.
  - MEM_RD: `mem_read`=1, `i_or_d`=1.
  - MEM_WR: `mem_write`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1.
  - R_EXEC: `alu_src_a`=1, `alu_op`=2.
  - R_WB: `reg_write`=1, `reg_dst`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=1, `pc_write_cond`=1, `pc_source`=1.
  - JUMP: `pc_write`=1, `pc_source`=2.
  - I_EXEC: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=3.
  - I_WB: `reg_write`=1.
- `ext_sign` is combinational from `opcode`: 0 for andi (001100) and ori (001101), 1 for all other opcodes, in every state.
- `instr_count` increments by 1 on each FETCH cycle with `mem_ready`=1. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset, sampled on a rising edge:
  - `state` = FETCH, `instr_count` = 0, `illegal` = 0.
  - While `reset`=1, all control outputs are forced to 0, and `ext_sign` is forced to 0.
- Reset mid-instruction, including mid-stall, aborts the instruction. No write strobe is asserted in the reset cycle.
- Instruction latency with zero wait states (`mem_ready` held 1):
  - j/beq: 3 cycles.
  - R, I-type, sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds 1 cycle. Requests (`mem_read`/`mem_write`) stay asserted and stable throughout the stall.
- `ir_write` and FETCH `pc_write` are asserted in exactly one cycle per fetch.
- `mem_read` and `mem_write` are never both 1.

## Configuration
- `ILLEGAL_OP_TRAP_EN` defined:
  - An illegal opcode in DECODE moves to TRAP.
  - In TRAP, `illegal`=1 and all strobes are 0. The block stays in TRAP until `reset`.
- `ILLEGAL_OP_TRAP_EN` undefined:
  - An illegal opcode in DECODE returns to FETCH and is treated as a NOP.
  - `illegal` pulses 1 for the DECODE cycle only.
  - State 12 is unreachable.

## Test plan
- Reset, then lw (100011) with `mem_ready`=1 → states 0,1,2,3,4,0 over 5 cycles; `reg_write`=1 and `mem_to_reg`=1 only in state 4; `instr_count`=1.
- andi (001100), then addi (001000) → `ext_sign`=0 during andi, then 1 during addi; `alu_src_b`=2 and `alu_op`=3 in I_EXEC; `reg_write`=1 in I_WB.
- sw with `mem_ready`=0 for 3 cycles in MEM_WR → `mem_write` held 1 and `i_or_d`=1 for 4 cycles; `mem_write`=0 afterwards; no `reg_write`.
- beq → `pc_write_cond`=1, `alu_op`=1, `pc_source`=1 in state 8 only; j → `pc_write`=1, `pc_source`=2 in state 9.
- Opcode 111111: with the macro → state 12, `illegal` held 1 for 10 cycles, then `reset` returns to state 0; without the macro → one-cycle `illegal` pulse, then FETCH.
- `reset` asserted during a MEM_RD stall → next state 0, `instr_count`=0, no `reg_write` pulse.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore main controller sequencing the multicycle MIPS datapath.
// Define ILLEGAL_OP_TRAP_EN to lock into TRAP on an illegal opcode; otherwise it retires as a NOP.
module mips_multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        ext_sign,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
        MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
        I_EXEC = 4'd10, I_WB = 4'd11, TRAP = 4'd12
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam state_t ILL_NEXT = TRAP;
`else
    localparam state_t ILL_NEXT = FETCH;
`endif
    state_t state_q, state_d;
    logic [31:0] count_q;
    logic legal, unused_zero;
    assign unused_zero = zero;
    assign legal = opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI};
    assign state = state_q;
    assign instr_count = count_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                     state_d = MEM_ADDR;
                    OP_R:                             state_d = R_EXEC;
                    OP_BEQ:                           state_d = BRANCH;
                    OP_J:                             state_d = JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = I_EXEC;
                    default:                          state_d = ILL_NEXT;
                endcase
            end
            MEM_ADDR: state_d = opcode == OP_SW ? MEM_WR : MEM_RD;
            MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
            MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
            R_EXEC:   state_d = R_WB;
            I_EXEC:   state_d = I_WB;
            TRAP:     state_d = ILL_NEXT;
            default:  state_d = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + {31'd0, state_q == FETCH && mem_ready};
        end
    end
    // Reset masks every strobe so an aborted instruction can never write.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE:   alu_src_b = 2'd3;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd2;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'd1;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'd1;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                end
                I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = 2'd3;
                end
                I_WB:     reg_write = 1'b1;
                default:  ;
            endcase
        end
    end
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal = !reset && state_q == TRAP;
`else
    assign illegal = !reset && state_q == DECODE && !legal;
`endif
    assign ext_sign = !reset && !(opcode == OP_ANDI || opcode == OP_ORI);
endmodule
